// File: rtl/brush_stamper.sv
// brush_stamper: stamps a square brush of the current color around the cursor
// into the 2-bit-per-pixel canvas RAM, one pixel per granted write cycle,
// with the footprint clipped to the visible canvas.
module brush_stamper #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int BRUSH_R = 1,
  parameter int ADDR_W  = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        CursorX,
  input  logic [9:0]        CursorY,
  input  logic              left_btn,
  input  logic [1:0]        paint_color,
  input  logic              ram_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ramIn,
  output logic              ram_write,
  output logic              busy,
  output logic              stroke_done
);

  typedef enum logic [1:0] {IDLE, SETUP, STAMP, DONE} stateT;

  localparam logic [10:0] R11  = 11'(BRUSH_R);
  localparam logic [10:0] XMAX = 11'(H_RES - 1);
  localparam logic [10:0] YMAX = 11'(V_RES - 1);

  stateT       state;
  logic [9:0]  cx, cy;
  logic [9:0]  lastX, lastY;
  logic        lastValid;
  logic [1:0]  color;
  logic [10:0] px, py;

  logic [10:0] cxW, cyW, xSum, ySum;
  logic [10:0] bx0, bx1, by0, by1;
  logic        offScreen, lastCol, lastPix;
  logic [10:0] nextPx, nextPy;

  // Canvas address y*H_RES + x; the 640-wide canvas uses shift-add instead of a multiplier.
  function automatic logic [ADDR_W-1:0] addrOf(input logic [10:0] y, input logic [10:0] x);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    if (H_RES == 640)
      addrOf = (yw << 9) + (yw << 7) + ADDR_W'(x);
    else
      addrOf = yw * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  // Clipped footprint bounds and row-major scan successor, all from latched values.
  always_comb begin
    cxW       = {1'b0, cx};
    cyW       = {1'b0, cy};
    xSum      = cxW + R11;
    ySum      = cyW + R11;
    bx0       = (cxW < R11) ? '0 : cxW - R11;
    by0       = (cyW < R11) ? '0 : cyW - R11;
    bx1       = (xSum > XMAX) ? XMAX : xSum;
    by1       = (ySum > YMAX) ? YMAX : ySum;
    offScreen = (bx0 > bx1) || (by0 > by1);
    lastCol   = (px == bx1);
    lastPix   = lastCol && (py == by1);
    nextPx    = lastCol ? bx0 : px + 11'd1;
    nextPy    = lastCol ? py + 11'd1 : py;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      ramIn       <= '0;
      busy        <= 1'b0;
      stroke_done <= 1'b0;
      lastValid   <= 1'b0;
      lastX       <= '0;
      lastY       <= '0;
      cx          <= '0;
      cy          <= '0;
      color       <= '0;
      px          <= '0;
      py          <= '0;
    end else begin
      case (state)
        IDLE: begin
          stroke_done <= 1'b0;
          if (!left_btn) begin
            lastValid <= 1'b0;
          end else if (!lastValid || CursorX != lastX || CursorY != lastY) begin
            // Cursor and color are captured on the detection edge so that
            // input changes during SETUP cannot affect the stamp.
            cx    <= CursorX;
            cy    <= CursorY;
            color <= paint_color;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          lastX     <= cx;
          lastY     <= cy;
          lastValid <= 1'b1;
          if (offScreen) begin
            stroke_done <= 1'b1;
            state       <= DONE;
          end else begin
            px        <= bx0;
            py        <= by0;
            ram_addr  <= addrOf(by0, bx0);
            ramIn     <= color;
            ram_write <= 1'b1;
            state     <= STAMP;
          end
        end
        STAMP: begin
          if (ram_grant) begin
            if (lastPix) begin
              ram_write   <= 1'b0;
              stroke_done <= 1'b1;
              state       <= DONE;
            end else begin
              px       <= nextPx;
              py       <= nextPy;
              ram_addr <= addrOf(nextPy, nextPx);
            end
          end
        end
        DONE: begin
          stroke_done <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brush_stamper.sv
// tb_brush_stamper: directed stamps with hand-computed canvas addresses.
module tb_brush_stamper;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  cursorX, cursorY;
  logic        leftBtn;
  logic [1:0]  paintColor;
  logic        ramGrant;
  logic [18:0] ramAddr;
  logic [1:0]  ramIn;
  logic        ramWrite, busy, strokeDone;

  brush_stamper #(.H_RES(640), .V_RES(480), .BRUSH_R(1), .ADDR_W(19)) dut (
    .Clk(clk), .Reset(reset), .CursorX(cursorX), .CursorY(cursorY),
    .left_btn(leftBtn), .paint_color(paintColor), .ram_grant(ramGrant),
    .ram_addr(ramAddr), .ramIn(ramIn), .ram_write(ramWrite),
    .busy(busy), .stroke_done(strokeDone)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int capQ[$];
  int expQ[$];
  bit doneSeen;
  int doneCyc, lastWriteCyc;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_btn;
    leftBtn = 1'b0;
    tick;
    tick;
  endtask

  // Runs one stamp from the IDLE cycle, capturing accepted writes.
  // grantMode 0: grant always high; 1: grant high every third cycle.
  task automatic collect(input int grantMode, input int expColor, input int maxCyc);
    logic        holdPrev;
    logic [18:0] hAddr;
    logic [1:0]  hData;
    capQ.delete();
    doneSeen     = 1'b0;
    doneCyc      = -1;
    lastWriteCyc = -1;
    holdPrev     = 1'b0;
    for (int k = 0; k < maxCyc && !doneSeen; k++) begin
      ramGrant = (grantMode == 0) ? 1'b1 : (k % 3 == 0);
      if (holdPrev) begin
        checkEq("holdAddr", 32'(ramAddr), 32'(hAddr));
        checkEq("holdData", 32'(ramIn), 32'(hData));
        checkEq("holdWrite", 32'(ramWrite), 1);
      end
      holdPrev = ramWrite && !ramGrant;
      hAddr    = ramAddr;
      hData    = ramIn;
      if (ramWrite && ramGrant) begin
        capQ.push_back(int'(ramAddr));
        checkEq("data", 32'(ramIn), 32'(expColor));
        lastWriteCyc = k;
      end
      if (strokeDone) begin
        doneSeen = 1'b1;
        doneCyc  = k;
      end
      tick;
    end
    ramGrant = 1'b1;
    checkEq("doneSeen", 32'(doneSeen), 1);
  endtask

  task automatic checkStamp(input string name);
    checkEq({name, "_count"}, 32'(capQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < capQ.size(); i++)
      checkEq({name, "_addr"}, 32'(capQ[i]), 32'(expQ[i]));
  endtask

  initial begin
    int nWrites;
    int seen;
    bit hit;

    reset = 1'b1; cursorX = '0; cursorY = '0; leftBtn = 1'b0;
    paintColor = '0; ramGrant = 1'b1;
    tick; tick; tick;
    checkEq("rst_write", 32'(ramWrite), 0);
    checkEq("rst_addr", 32'(ramAddr), 0);
    checkEq("rst_ramIn", 32'(ramIn), 0);
    checkEq("rst_busy", 32'(busy), 0);
    checkEq("rst_done", 32'(strokeDone), 0);
    reset = 1'b0;
    tick;

    // Centered stamp, full-rate grant.
    cursorX = 10'd178; cursorY = 10'd452; paintColor = 2'b10; leftBtn = 1'b1;
    collect(0, 2, 40);
    expQ = '{288817, 288818, 288819, 289457, 289458, 289459, 290097, 290098, 290099};
    checkStamp("center");
    checkEq("center_lastWr", 32'(lastWriteCyc), 10);
    checkEq("center_doneCyc", 32'(doneCyc), 11);
    checkEq("center_busyAfter", 32'(busy), 0);

    // Button held, cursor still: no writes.
    nWrites = 0;
    for (int i = 0; i < 50; i++) begin
      if (ramWrite || busy) nWrites++;
      tick;
    end
    checkEq("hold_writes", 32'(nWrites), 0);

    // Cursor moved one pixel right while held.
    cursorX = 10'd179;
    collect(0, 2, 40);
    expQ = '{288818, 288819, 288820, 289458, 289459, 289460, 290098, 290099, 290100};
    checkStamp("moved");

    release_btn;
    cursorX = 10'd0; cursorY = 10'd0; paintColor = 2'b01; leftBtn = 1'b1;
    collect(0, 1, 40);
    expQ = '{0, 1, 640, 641};
    checkStamp("corner00");
    checkEq("corner00_doneCyc", 32'(doneCyc), 6);

    release_btn;
    cursorX = 10'd639; cursorY = 10'd479; paintColor = 2'b11; leftBtn = 1'b1;
    collect(0, 3, 40);
    expQ = '{306558, 306559, 307198, 307199};
    checkStamp("cornerMax");

    // Intermittent grant.
    release_btn;
    cursorX = 10'd178; cursorY = 10'd452; paintColor = 2'b01; leftBtn = 1'b1;
    collect(1, 1, 80);
    expQ = '{288817, 288818, 288819, 289457, 289458, 289459, 290097, 290098, 290099};
    checkStamp("grantToggle");
    checkEq("grantToggle_busyAfter", 32'(busy), 0);

    // Footprint entirely off-screen.
    release_btn;
    cursorX = 10'd700; cursorY = 10'd100; paintColor = 2'b10; leftBtn = 1'b1;
    collect(0, 2, 40);
    checkEq("offscreen_count", 32'(capQ.size()), 0);
    checkEq("offscreen_busyAfter", 32'(busy), 0);

    // Reset on the 4th write, then the held button restarts the stamp.
    release_btn;
    cursorX = 10'd178; cursorY = 10'd452; paintColor = 2'b10; leftBtn = 1'b1;
    ramGrant = 1'b1;
    seen = 0;
    hit  = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (ramWrite) begin
        if (seen == 3) begin
          reset = 1'b1;
          hit   = 1'b1;
        end else begin
          seen++;
        end
      end
      tick;
    end
    checkEq("rstMid_hit", 32'(hit), 1);
    checkEq("rstMid_write", 32'(ramWrite), 0);
    checkEq("rstMid_busy", 32'(busy), 0);
    reset = 1'b0;
    collect(0, 2, 40);
    expQ = '{288817, 288818, 288819, 289457, 289458, 289459, 290097, 290098, 290099};
    checkStamp("restart");
    checkEq("restart_doneCyc", 32'(doneCyc), 11);

    release_btn;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
